// File: rtl/lfsr_prbs_if.sv
// Control and observation bundle for the lfsr_prbs generator.
// The master drives enable/load/seed_in; the slave (generator) returns state and status.
interface lfsr_prbs_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] state;
  logic             lockup;
  logic             wrap;
  logic [WIDTH-1:0] period;

  modport master (
    output enable, load, seed_in,
    input  state, lockup, wrap, period
  );

  modport slave (
    input  enable, load, seed_in,
    output state, lockup, wrap, period
  );
endinterface

// File: rtl/lfsr_prbs.sv
// Parametrised Fibonacci LFSR PRBS source with seed load, lock-up recovery
// and period measurement between successive returns to the reference value.
module lfsr_prbs #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h88),
  parameter bit               XNOR  = 1'b1,
  parameter int               STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic        clk,
  input  logic        reset,
  lfsr_prbs_if.slave  bus
);

  localparam logic [WIDTH-1:0] LOCK_VAL = {WIDTH{XNOR}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] period_q;
  logic             wrap_q;
  logic             lockup_q;
  logic [WIDTH-1:0] stepped;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] s);
    logic fb;
    fb = (^(s & TAPS)) ^ XNOR;
    return {s[WIDTH-2:0], fb};
  endfunction

  always_comb begin
    stepped = state_q;
    // NOTE: blocking assignment so each iteration builds on the previous shift.
    for (int i = 0; i < STEPS; i++) begin
      stepped = shift1(stepped);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEED;
      ref_q    <= SEED;
      count_q  <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
      if (bus.load) begin
        count_q <= '0;
        if (bus.seed_in == LOCK_VAL) begin
          state_q  <= SEED;
          ref_q    <= SEED;
          lockup_q <= 1'b1;
        end else begin
          state_q <= bus.seed_in;
          ref_q   <= bus.seed_in;
        end
      end else if (bus.enable) begin
        if (state_q == LOCK_VAL) begin
          // Only reachable with a tap/seed combination that can enter lock-up.
          state_q  <= SEED;
          ref_q    <= SEED;
          count_q  <= '0;
          lockup_q <= 1'b1;
        end else begin
          state_q <= stepped;
          if (stepped == ref_q) begin
            wrap_q   <= 1'b1;
            period_q <= count_q + ONE;
            count_q  <= '0;
          end else if (count_q != '1) begin
            count_q <= count_q + ONE;
          end
        end
      end
    end
  end

  assign bus.state  = state_q;
  assign bus.lockup = lockup_q;
  assign bus.wrap   = wrap_q;
  assign bus.period = period_q;

endmodule

// File: tb/tb_lfsr_prbs.sv
// Directed bench for lfsr_prbs: default, 4-bit maximal-length and 4-steps-per-cycle
// instances driven from one linear stimulus sequence with immediate-assertion checks.
module tb_lfsr_prbs;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lfsr_prbs_if #(.WIDTH(8)) d_if ();
  lfsr_prbs_if #(.WIDTH(4)) w_if ();
  lfsr_prbs_if #(.WIDTH(8)) s_if ();

  lfsr_prbs u_def (
    .clk   (clk),
    .reset (reset),
    .bus   (d_if)
  );

  lfsr_prbs #(
    .WIDTH (4),
    .TAPS  (4'hC),
    .XNOR  (1'b0),
    .STEPS (1),
    .SEED  (4'h1)
  ) u_w4 (
    .clk   (clk),
    .reset (reset),
    .bus   (w_if)
  );

  lfsr_prbs #(.STEPS(4)) u_s4 (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: 8-bit XNOR with taps 7 and 3.
  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[3])};
  endfunction

  // Independent reference: 4-bit XOR with taps 3 and 2.
  function automatic logic [3:0] step4(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  initial begin
    logic [7:0] exp_seq [5];
    logic [7:0] m8;
    logic [3:0] m4;
    logic       en;

    exp_seq[0] = 8'h01; exp_seq[1] = 8'h03; exp_seq[2] = 8'h07;
    exp_seq[3] = 8'h0F; exp_seq[4] = 8'h1E;

    reset = 1'b1;
    d_if.enable = 1'b0; d_if.load = 1'b0; d_if.seed_in = '0;
    w_if.enable = 1'b0; w_if.load = 1'b0; w_if.seed_in = '0;
    s_if.enable = 1'b0; s_if.load = 1'b0; s_if.seed_in = '0;

    // Reset values
    tick();
    check("rst_state",  32'(d_if.state),  32'h00);
    check("rst_wrap",   32'(d_if.wrap),   32'h0);
    check("rst_lockup", 32'(d_if.lockup), 32'h0);
    check("rst_period", 32'(d_if.period), 32'h00);
    check("rst_w4",     32'(w_if.state),  32'h1);
    reset = 1'b0;

    // Default instance: five enables from zero
    d_if.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("def_seq%0d", i), 32'(d_if.state), 32'(exp_seq[i]));
      check($sformatf("def_wrap%0d", i), 32'(d_if.wrap | d_if.lockup), 32'h0);
    end

    // Loading the lock-up value substitutes SEED and pulses lockup once
    d_if.enable = 1'b0; d_if.load = 1'b1; d_if.seed_in = 8'hFF;
    tick();
    check("lk_state",  32'(d_if.state),  32'h00);
    check("lk_pulse",  32'(d_if.lockup), 32'h1);
    d_if.load = 1'b0;
    tick();
    check("lk_clear",  32'(d_if.lockup), 32'h0);
    check("lk_hold",   32'(d_if.state),  32'h00);
    d_if.enable = 1'b1;
    tick();
    check("lk_step",   32'(d_if.state),  32'h01);

    // load has priority over enable; no step taken
    d_if.load = 1'b1; d_if.seed_in = 8'h5A;
    tick();
    check("ld_state",  32'(d_if.state),  32'h5A);
    check("ld_lockup", 32'(d_if.lockup), 32'h0);
    check("ld_wrap",   32'(d_if.wrap),   32'h0);
    d_if.load = 1'b0; d_if.enable = 1'b0;
    tick();
    check("ld_hold",   32'(d_if.state),  32'h5A);

    // STEPS=4 instance: 4 then 8 shifts from zero
    s_if.enable = 1'b1;
    tick();
    check("s4_first",  32'(s_if.state), 32'h0F);
    tick();
    check("s4_second", 32'(s_if.state), 32'hF0);
    s_if.enable = 1'b0;

    // 4-bit maximal sequence: wraps after 15 and 30 enables
    m4 = 4'h1;
    w_if.enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      m4 = step4(m4);
      check($sformatf("w4_state%0d", i), 32'(w_if.state), 32'(m4));
      check($sformatf("w4_wrap%0d", i), 32'(w_if.wrap), (i == 14 || i == 29) ? 32'h1 : 32'h0);
      if (i == 14 || i == 29)
        check($sformatf("w4_period%0d", i), 32'(w_if.period), 32'd15);
    end
    check("w4_back_to_seed", 32'(w_if.state), 32'h1);
    for (int i = 0; i < 3; i++) tick();

    // Reset mid-run overrides enable
    reset = 1'b1;
    tick();
    check("mid_rst_w4",     32'(w_if.state),  32'h1);
    check("mid_rst_period", 32'(w_if.period), 32'h0);
    check("mid_rst_wrap",   32'(w_if.wrap),   32'h0);
    check("mid_rst_def",    32'(d_if.state),  32'h00);
    reset = 1'b0;
    w_if.enable = 1'b0;

    // Random enable against the single-step model
    m8 = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      en = 1'($urandom_range(0, 1));
      d_if.enable = en;
      tick();
      if (en) m8 = step8(m8);
      check($sformatf("rnd%0d", i), 32'(d_if.state), 32'(m8));
    end
    d_if.enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs.md
# lfsr_prbs

Parametrised Fibonacci LFSR pseudo-random sequence generator, the general-width successor to the fixed 8-bit XNOR LFSR. It supports a configurable width, tap mask, XOR/XNOR feedback and multiple shifts per clock. It adds seed loading, lock-up state detection with automatic recovery, and sequence-period measurement. It sits beside datapath blocks as a PRBS source for scramblers, test-pattern generation and BIST stimulus.

## Interface
- WIDTH, 8, register width in bits (≥3).
- TAPS, 8'h88, tap mask; bit i = 1 includes state[i] in feedback (default = bits 7 and 3).
- XNOR, 1, 1 = XNOR feedback, 0 = XOR feedback.
- STEPS, 1, single-bit shifts applied per enabled cycle (1..WIDTH).
- SEED, 0, state after reset and lock-up recovery; must not equal the lock-up value.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  advance sequence by STEPS shifts this cycle.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  value to load.
- state  out  WIDTH  current LFSR register.
- lockup  out  1  one-cycle pulse: lock-up value was loaded or found, and SEED was substituted.
- wrap  out  1  one-cycle pulse: state returned to reference value.
- period  out  WIDTH  enabled-cycle count of the last completed cycle; holds until the next wrap.

## Operation
- Single shift function: fb = XOR over state[i] where TAPS[i] = 1, inverted if XNOR=1. next = {state[WIDTH-2:0], fb}, shifting left with fb entering the LSB.
- Enabled cycle applies the single shift STEPS times combinationally. The result is the STEPS-fold composition.
- Lock-up value: all-ones when XNOR=1, all-zeros when XOR.
- Priority: reset > load > enable > hold.
- Reset: state=SEED, ref=SEED, count=0, period=0, wrap=0, lockup=0.
- load=1:
  - state=seed_in and ref=seed_in, or SEED for both if seed_in equals the lock-up value, with lockup=1 next cycle.
  - count=0; no step taken even if enable=1; wrap=0.
- enable=1, load=0, state equals the lock-up value (reachable only via parameter misuse): state=SEED, ref=SEED, count=0, lockup=1.
- enable=1, load=0, normal:
  - state advances.
  - If the advanced value equals ref: wrap=1, period=count+1, count=0.
  - Otherwise count=count+1, saturating at all-ones with no wrap on saturation.
- enable=0, load=0: all registers hold; wrap=0, lockup=0.
- Wrap is compared only against the end-of-cycle state. With STEPS>1, intermediate matches are not detected.

## Timing
- All outputs are registered; state updates on the edge where load/enable is sampled, so there is 1-cycle latency.
- wrap and lockup are high for exactly the one cycle following the causing edge, and low otherwise.
- period updates on the same edge that asserts wrap.
- reset asserted mid-sequence overrides load/enable in that cycle; the next cycle shows reset values.
- Back-to-back enables produce one advance per cycle with no bubbles.

## Test plan
- Defaults, reset then enable held 5 cycles -> state 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1E; no wrap, no lockup.
- Defaults, load=1 with seed_in=0xFF -> state 0x00, lockup=1 for one cycle, count=0. Then enable -> 0x01.
- WIDTH=4, TAPS=4'hC, XNOR=0, SEED=1, enable 15 cycles -> wrap pulses after the 15th enable, period=15, state=0x1. Cycles 16–30 produce a second wrap.
- Defaults with STEPS=4, reset then one enable -> state 0x0F. A second enable -> state equals 8 single steps from 0.
- load=1 and enable=1 together with seed_in=0x5A -> state 0x5A, no step, count=0. reset during a run -> state 0x00, period 0.
- enable toggled randomly against a single-step reference model for 1000 cycles -> state matches every cycle; holds exactly when enable=0.
